// File: rtl/fetch_stage_pkg.sv
// Shared processor definitions used by the fetch stage: NOP encoding,
// fetch FSM state encoding and the default reset PC.
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSN         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_RUN   = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_reg32.sv
// Generic 32-bit enabled register with asynchronous active-low reset
// to a parameterised value.
module fetch_stage_reg32 #(
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] d,
    output logic [31:0] q
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage in front of a synchronous imem: issues word
// addresses, presents the returned instruction to the F/D latch.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_EMPTY | no valid instruction on imem_q (after reset or redirect)
// ST_RUN   | imem_q / hold buffer carries the instruction at pc_d1
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          IMEM_AW  = 12
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_target,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_q,
    output logic [31:0]        out_IR,
    output logic [31:0]        out_PC_next,
    output logic               fd_wren,
    output logic               out_valid
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic [31:0]  pc_d1;
    logic [31:0]  hold_buf;
    logic         hold_valid;
    logic         pc_en;
    logic         running;

    assign running = (state_q == ST_RUN);

    fetch_stage_reg32 #(
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clock (clock),
        .reset (reset),
        .en    (pc_en),
        .d     (pc_d),
        .q     (pc_q)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // EMPTY always advances so the pipeline refills even under stall.
    always_comb begin
        state_d = state_q;
        pc_en   = 1'b0;
        pc_d    = pc_q + 32'd1;
        if (redirect) begin
            state_d = ST_EMPTY;
            pc_en   = 1'b1;
            pc_d    = redirect_target;
        end else begin
            state_d = ST_RUN;
            pc_en   = !(stall && running);
        end
    end

    // While stalled, imem keeps reading pc_q (the next instruction), so the
    // displayed one must be parked in the hold buffer on the first stall edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_d1      <= RESET_PC;
            hold_valid <= 1'b0;
            hold_buf   <= NOP_INSN;
        end else begin
            if (!redirect && pc_en) begin
                pc_d1 <= pc_q;
            end
            if (redirect || !stall) begin
                hold_valid <= 1'b0;
            end else if (running && !hold_valid) begin
                hold_valid <= 1'b1;
                hold_buf   <= imem_q;
            end
        end
    end

    always_comb begin
        out_valid   = running;
        out_IR      = NOP_INSN;
        out_PC_next = 32'h0000_0000;
        if (running) begin
            out_IR      = hold_valid ? hold_buf : imem_q;
            out_PC_next = pc_d1 + 32'd1;
        end
    end

    assign fd_wren   = ~stall;
    assign imem_addr = pc_q[IMEM_AW-1:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// stall/redirect traffic against a program-order reference model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic [11:0] imem_addr;
    logic [31:0] imem_q;
    logic [31:0] out_IR;
    logic [31:0] out_PC_next;
    logic        fd_wren;
    logic        out_valid;

    logic        stall_w = 1'b0;
    logic        redirect_w = 1'b0;
    logic [31:0] redirect_target_w = 32'h0;
    logic [11:0] imem_addr_w;
    logic [31:0] imem_q_w;
    logic [31:0] out_IR_w;
    logic [31:0] out_PC_next_w;
    logic        fd_wren_w;
    logic        out_valid_w;

    logic [31:0] mem [0:4095];

    int n_cmp = 0;
    int n_fail = 0;

    // reference model: program-order view of what the F/D latch should see
    logic        m_valid;
    logic [31:0] m_disp;
    logic [31:0] m_next;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        imem_q   <= mem[imem_addr];
        imem_q_w <= mem[imem_addr_w];
    end

    fetch_stage dut (
        .clock           (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_q          (imem_q),
        .out_IR          (out_IR),
        .out_PC_next     (out_PC_next),
        .fd_wren         (fd_wren),
        .out_valid       (out_valid)
    );

    fetch_stage #(
        .RESET_PC (32'h0000_0FFF),
        .IMEM_AW  (12)
    ) dut_w (
        .clock           (clk),
        .reset           (reset),
        .stall           (stall_w),
        .redirect        (redirect_w),
        .redirect_target (redirect_target_w),
        .imem_addr       (imem_addr_w),
        .imem_q          (imem_q_w),
        .out_IR          (out_IR_w),
        .out_PC_next     (out_PC_next_w),
        .fd_wren         (fd_wren_w),
        .out_valid       (out_valid_w)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // leaves reset released at posedge+1, i.e. in the first cycle after reset
    task automatic do_reset();
        stall    = 1'b0;
        redirect = 1'b0;
        reset    = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        stall = 1'b0;
        redirect = 1'b0;
        reset = 1'b1;
        step();
        step();
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_IR !== 32'h0) begin n_fail++; $display("FAIL reset_ir: got %h want 0", out_IR); end
        n_cmp++; if (out_PC_next !== 32'h0) begin n_fail++; $display("FAIL reset_pcn: got %h want 0", out_PC_next); end
        n_cmp++; if (imem_addr !== 12'h000) begin n_fail++; $display("FAIL reset_addr: got %h want 000", imem_addr); end
        n_cmp++; if (fd_wren !== 1'b1) begin n_fail++; $display("FAIL reset_wren0: got %b want 1", fd_wren); end
        n_cmp++; if (imem_addr_w !== 12'hFFF) begin n_fail++; $display("FAIL reset_addr_w: got %h want fff", imem_addr_w); end
        stall = 1'b1;
        #1;
        n_cmp++; if (fd_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren1: got %b want 0", fd_wren); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_hold_valid: got %b want 0", out_valid); end
        stall = 1'b0;
    endtask

    task automatic test_sequence();
        do_reset();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL seq_c1_valid: got %b want 0", out_valid); end
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d]: got %b want 1", i, out_valid); end
            n_cmp++; if (out_IR !== mem[i]) begin n_fail++; $display("FAIL seq_ir[%0d]: got %h want %h", i, out_IR, mem[i]); end
            n_cmp++; if (out_PC_next !== 32'(i + 1)) begin n_fail++; $display("FAIL seq_pcn[%0d]: got %h want %h", i, out_PC_next, i + 1); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        step();
        step();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (out_IR !== mem[1]) begin n_fail++; $display("FAIL stall_ir[%0d]: got %h want %h", k, out_IR, mem[1]); end
            n_cmp++; if (out_PC_next !== 32'd2) begin n_fail++; $display("FAIL stall_pcn[%0d]: got %h want 2", k, out_PC_next); end
            n_cmp++; if (fd_wren !== 1'b0) begin n_fail++; $display("FAIL stall_wren[%0d]: got %b want 0", k, fd_wren); end
            step();
        end
        stall = 1'b0;
        #1;
        n_cmp++; if (out_IR !== mem[1]) begin n_fail++; $display("FAIL stall_rel_ir: got %h want %h", out_IR, mem[1]); end
        step();
        n_cmp++; if (out_IR !== mem[2]) begin n_fail++; $display("FAIL stall_after_c: got %h want %h", out_IR, mem[2]); end
        n_cmp++; if (out_PC_next !== 32'd3) begin n_fail++; $display("FAIL stall_after_pcn3: got %h want 3", out_PC_next); end
        step();
        n_cmp++; if (out_IR !== mem[3]) begin n_fail++; $display("FAIL stall_after_d: got %h want %h", out_IR, mem[3]); end
        n_cmp++; if (out_PC_next !== 32'd4) begin n_fail++; $display("FAIL stall_after_pcn4: got %h want 4", out_PC_next); end
    endtask

    task automatic test_redirect();
        do_reset();
        step();
        step();
        step();
        redirect = 1'b1;
        redirect_target = 32'h40;
        step();
        redirect = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_bubble_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_IR !== 32'h0) begin n_fail++; $display("FAIL redir_bubble_ir: got %h want 0", out_IR); end
        n_cmp++; if (imem_addr !== 12'h040) begin n_fail++; $display("FAIL redir_addr: got %h want 040", imem_addr); end
        step();
        n_cmp++; if (out_IR !== mem[12'h040]) begin n_fail++; $display("FAIL redir_ir: got %h want %h", out_IR, mem[12'h040]); end
        n_cmp++; if (out_PC_next !== 32'h41) begin n_fail++; $display("FAIL redir_pcn: got %h want 41", out_PC_next); end
    endtask

    task automatic test_redirect_stall();
        do_reset();
        step();
        step();
        stall = 1'b1;
        step();
        step();
        redirect = 1'b1;
        redirect_target = 32'h123;
        step();
        redirect = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rs_bubble_valid: got %b want 0", out_valid); end
        step();
        n_cmp++; if (out_IR !== mem[12'h123]) begin n_fail++; $display("FAIL rs_ir: got %h want %h", out_IR, mem[12'h123]); end
        n_cmp++; if (out_PC_next !== 32'h124) begin n_fail++; $display("FAIL rs_pcn: got %h want 124", out_PC_next); end
        stall = 1'b0;
        step();
        n_cmp++; if (out_IR !== mem[12'h124]) begin n_fail++; $display("FAIL rs_next_ir: got %h want %h", out_IR, mem[12'h124]); end
    endtask

    task automatic test_async_reset();
        do_reset();
        step();
        step();
        stall = 1'b1;
        step();
        step();
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_IR !== 32'h0) begin n_fail++; $display("FAIL areset_ir: got %h want 0", out_IR); end
        n_cmp++; if (out_PC_next !== 32'h0) begin n_fail++; $display("FAIL areset_pcn: got %h want 0", out_PC_next); end
        n_cmp++; if (imem_addr !== 12'h000) begin n_fail++; $display("FAIL areset_addr: got %h want 000", imem_addr); end
        stall = 1'b0;
        step();
        reset = 1'b1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_c1_valid: got %b want 0", out_valid); end
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++; if (out_IR !== mem[i]) begin n_fail++; $display("FAIL areset_ir[%0d]: got %h want %h", i, out_IR, mem[i]); end
            n_cmp++; if (out_PC_next !== 32'(i + 1)) begin n_fail++; $display("FAIL areset_pcn[%0d]: got %h want %h", i, out_PC_next, i + 1); end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        n_cmp++; if (imem_addr_w !== 12'hFFF) begin n_fail++; $display("FAIL wrap_addr0: got %h want fff", imem_addr_w); end
        step();
        n_cmp++; if (imem_addr_w !== 12'h000) begin n_fail++; $display("FAIL wrap_addr1: got %h want 000", imem_addr_w); end
        n_cmp++; if (out_PC_next_w !== 32'h1000) begin n_fail++; $display("FAIL wrap_pcn0: got %h want 1000", out_PC_next_w); end
        n_cmp++; if (out_IR_w !== mem[12'hFFF]) begin n_fail++; $display("FAIL wrap_ir0: got %h want %h", out_IR_w, mem[12'hFFF]); end
        step();
        n_cmp++; if (out_PC_next_w !== 32'h1001) begin n_fail++; $display("FAIL wrap_pcn1: got %h want 1001", out_PC_next_w); end
        n_cmp++; if (out_IR_w !== mem[0]) begin n_fail++; $display("FAIL wrap_ir1: got %h want %h", out_IR_w, mem[0]); end
        // full 32-bit wrap on the default instance
        redirect = 1'b1;
        redirect_target = 32'hFFFF_FFFF;
        step();
        redirect = 1'b0;
        step();
        n_cmp++; if (out_PC_next !== 32'h0) begin n_fail++; $display("FAIL wrap32_pcn0: got %h want 0", out_PC_next); end
        n_cmp++; if (imem_addr !== 12'h000) begin n_fail++; $display("FAIL wrap32_addr: got %h want 000", imem_addr); end
        step();
        n_cmp++; if (out_PC_next !== 32'h1) begin n_fail++; $display("FAIL wrap32_pcn1: got %h want 1", out_PC_next); end
        n_cmp++; if (out_IR !== mem[0]) begin n_fail++; $display("FAIL wrap32_ir1: got %h want %h", out_IR, mem[0]); end
    endtask

    task automatic test_random();
        logic        st;
        logic        rd;
        logic [31:0] tgt;
        logic [11:0] idx;
        logic [31:0] exp_ir;
        logic [31:0] exp_pcn;
        do_reset();
        m_valid = 1'b0;
        m_next  = 32'h0;
        m_disp  = 32'h0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
                m_valid = 1'b0;
                m_next  = 32'h0;
            end
            st  = ($urandom_range(0, 99) < 35);
            rd  = ($urandom_range(0, 99) < 8);
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFE + 32'($urandom_range(0, 1))) : $urandom;
            stall = st;
            redirect = rd;
            redirect_target = tgt;
            #1;
            n_cmp++; if (fd_wren !== ~st) begin n_fail++; $display("FAIL rnd_wren[%0d]: got %b want %b", n, fd_wren, ~st); end
            step();
            if (rd) begin
                m_valid = 1'b0;
                m_next  = tgt;
            end else if (!m_valid || !st) begin
                m_disp  = m_next;
                m_next  = m_next + 32'd1;
                m_valid = 1'b1;
            end
            idx     = m_disp[11:0];
            exp_ir  = m_valid ? mem[idx] : 32'h0;
            exp_pcn = m_valid ? (m_disp + 32'd1) : 32'h0;
            idx     = m_next[11:0];
            n_cmp++; if (out_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, out_valid, m_valid); end
            n_cmp++; if (out_IR !== exp_ir) begin n_fail++; $display("FAIL rnd_ir[%0d]: got %h want %h", n, out_IR, exp_ir); end
            n_cmp++; if (out_PC_next !== exp_pcn) begin n_fail++; $display("FAIL rnd_pcn[%0d]: got %h want %h", n, out_PC_next, exp_pcn); end
            n_cmp++; if (imem_addr !== idx) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h want %h", n, imem_addr, idx); end
        end
        stall = 1'b0;
        redirect = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i] = $urandom | 32'h1;
        end
        test_reset();
        test_sequence();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_async_reset();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have parameter IMEM_AW, default 12, instruction-memory word-address width.
REQ-003 SHALL have port clock, input, 1, sole clock; all state rising-edge.
REQ-004 SHALL have port reset, input, 1; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port stall, input, 1, hazard-unit hold request for the F/D boundary.
REQ-006 SHALL have port redirect, input, 1, taken branch/jump from a later stage.
REQ-007 SHALL have port redirect_target, input, 32, word-addressed PC to fetch next.
REQ-008 SHALL have port imem_addr, output, IMEM_AW, word address to a synchronous imem.
REQ-009 SHALL have port imem_q, input, 32, imem data, valid the cycle after its address is sampled.
REQ-010 SHALL have port out_IR, output, 32, instruction to the F/D latch.
REQ-011 SHALL have port out_PC_next, output, 32, PC+1 of out_IR.
REQ-012 SHALL have port fd_wren, output, 1, F/D latch write enable.
REQ-013 SHALL have port out_valid, output, 1, out_IR is a real instruction.

Function
REQ-014 SHALL hold pc_q (next address to issue) and pc_d1 (address of instruction currently returned); imem_addr = pc_q[IMEM_AW-1:0] combinationally.
REQ-015 SHALL implement states EMPTY (no valid instruction returned) and RUN.
REQ-016 EMPTY, any edge without redirect: pc_q <= pc_q+1, pc_d1 <= pc_q, -> RUN, regardless of stall.
REQ-017 RUN, stall=0, no redirect: pc_q <= pc_q+1, pc_d1 <= pc_q, hold buffer cleared.
REQ-018 RUN, stall=1, no redirect: pc_q and pc_d1 hold; on first stall edge a 1-entry hold buffer captures the displayed instruction and sets hold_valid.
REQ-019 out_IR SHALL be hold buffer when hold_valid, else imem_q; no instruction lost or duplicated across any stall length.
REQ-020 redirect=1 at an edge (any state, overrides stall): pc_q <= redirect_target, hold_valid <= 0, -> EMPTY.
REQ-021 In EMPTY: out_valid=0, out_IR=32'h0 (NOP), out_PC_next=0; in RUN: out_valid=1, out_PC_next=pc_d1+1.
REQ-022 fd_wren SHALL equal ~stall combinationally.
REQ-023 Redirect penalty SHALL be exactly one EMPTY cycle; target instruction appears on out_IR in the second cycle after the redirect edge.
REQ-024 pc_q and out_PC_next SHALL wrap modulo 2^32 (32'hFFFF_FFFF+1 = 0); imem_addr wraps with pc_q low bits.

Reset
REQ-025 reset=0 SHALL immediately force pc_q=RESET_PC, pc_d1=RESET_PC, state EMPTY, hold_valid=0, hold buffer 0, independent of clock.
REQ-026 During and after reset until first edge: out_valid=0, out_IR=0, out_PC_next=0, imem_addr=RESET_PC[IMEM_AW-1:0], fd_wren=~stall.
REQ-027 Reset asserted mid-stall or mid-redirect SHALL discard all in-flight state; first fetch after release is RESET_PC.

Structure
REQ-028 NOP encoding (32'h0), state encodings and default RESET_PC SHALL live in the shared processor definitions package/header.
REQ-029 pc_q SHALL be built from the team's existing 32-bit register sub-module (enable = ~(stall & RUN) | redirect); other logic inline.

Verification
REQ-030 Reset release, stall=0, imem[0..3]=A,B,C,D -> cycle1 out_valid=0; cycles2-5 out_IR=A,B,C,D with out_PC_next=1,2,3,4.
REQ-031 Stall=1 for 3 cycles while out_IR=B -> out_IR=B, out_PC_next=2, fd_wren=0 throughout; after release C then D, no repeat/skip.
REQ-032 redirect=1, target=0x40, while out_IR=C -> next cycle out_valid=0, out_IR=0; following cycle out_IR=imem[0x40], out_PC_next=0x41.
REQ-033 redirect=1 and stall=1 same cycle with hold_valid=1 -> redirect wins; hold cleared; imem[target] appears two cycles later.
REQ-034 RESET_PC=0xFFF, IMEM_AW=12 -> imem_addr 0xFFF then 0x000; out_PC_next 0x1000 then 0x1001.
REQ-035 Assert reset asynchronously mid-stall -> outputs zero within same cycle; after release fetch restarts at RESET_PC, per REQ-030.
